ifetch_unit: RTL and testbench

//  Instruction fetch stage feeding the main controller/decoder. Holds the PC, issues one

---
 rtl/ifetch_unit.sv | 128 ++++++++++++
 tb/tb_ifetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, issues one imem request per instruction and
// selects the next PC. Define IFETCH_DELAY_SLOT_EN for MIPS branch-delay-slot behaviour.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        jumpr,
  input  logic [31:0] signimm,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        fetch_err
);

  localparam int unsigned   CW       = $clog2(WAIT_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_VALID} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   target;
  logic [31:0]   pc_next;
  logic          retire;
  logic          timeout;
  logic          spurious;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)          state_nxt = S_VALID;
        else if (cnt == CNT_LAST) state_nxt = S_REQ;
      end
      S_VALID: if (advance) state_nxt = S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      S_REQ:   imem_req    = 1'b1;
      S_VALID: instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign pcplus4   = pc + 32'd4;

  assign retire   = (state == S_VALID) && advance;
  assign timeout  = (state == S_WAIT) && !imem_rvalid && (cnt == CNT_LAST);
  assign spurious = imem_rvalid && ((state == S_REQ) || (state == S_VALID));

  always_comb begin
    target = pcplus4;
    if (jumpr)      target = jr_target;
    else if (jump)  target = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (pcsrc) target = pcplus4 + {signimm[29:0], 2'b00};
  end

`ifdef IFETCH_DELAY_SLOT_EN
  logic        redirect;
  logic        pend_valid;
  logic [31:0] pend_pc;

  assign redirect = jumpr | jump | pcsrc;

  // The slot instruction always retires to the stored target; its own redirects are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (retire) begin
      if (pend_valid) begin
        pend_valid <= 1'b0;
      end else if (redirect) begin
        pend_valid <= 1'b1;
        pend_pc    <= target;
      end
    end
  end

  assign pc_next = pend_valid ? pend_pc : pcplus4;
`else
  assign pc_next = target;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      instr     <= '0;
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == S_REQ)                     cnt <= '0;
      else if (state == S_WAIT && !imem_rvalid) cnt <= cnt + CW'(1);
      if (state == S_WAIT && imem_rvalid)     instr <= imem_rdata;
      if (timeout || spurious)                fetch_err <= 1'b1;
      if (retire)                             pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed cases plus randomized fetch/redirect traffic
// against a transaction-level PC model (honours IFETCH_DELAY_SLOT_EN).
module tb_ifetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        advance = 1'b0;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;
  logic        jumpr = 1'b0;
  logic [31:0] signimm = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        fetch_err;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RPC), .WAIT_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
    .advance(advance), .pcsrc(pcsrc), .jump(jump), .jumpr(jumpr),
    .signimm(signimm), .jr_target(jr_target),
    .pc(pc), .pcplus4(pcplus4), .fetch_err(fetch_err)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [31:0] m_pc;
  logic        m_err;
  logic        m_pend;
  logic [31:0] m_pend_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc = RPC; m_err = 1'b0; m_pend = 1'b0; m_pend_pc = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    check("rst_valid", instr_valid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, RPC);
    check("rst_instr", instr, 32'h0);
    check("rst_err", fetch_err, 1'b0);
    reset = 1'b1;
    model_reset();
    tick();
    check("first_req", imem_req, 1'b1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 40) begin tick(); n++; end
    check("req_seen", imem_req, 1'b1);
    check("req_addr", imem_addr, m_pc);
  endtask

  // One full instruction: request, response after lat cycles, hold, then retire with redirects.
  task automatic step(input logic [31:0] word, input int lat, input int hold, input bit spur,
                      input bit br, input bit jmp, input bit jr,
                      input logic [31:0] simm, input logic [31:0] jrt);
    logic [31:0] tgt;
    wait_req();
    repeat (lat) begin
      tick();
      check("wait_req_low", imem_req, 1'b0);
      check("wait_not_valid", instr_valid, 1'b0);
    end
    imem_rvalid = 1'b1; imem_rdata = word;
    tick();
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    check("valid", instr_valid, 1'b1);
    check("instr", instr, word);
    check("op", op, word >> 26);
    check("funct", funct, word & 32'h3F);
    check("pc", pc, m_pc);
    check("pcplus4", pcplus4, m_pc + 32'd4);
    check("err", fetch_err, m_err);
    if (spur) begin
      imem_rvalid = 1'b1; imem_rdata = ~word;
      tick();
      imem_rvalid = 1'b0;
      m_err = 1'b1;
      check("spur_instr", instr, word);
      check("spur_err", fetch_err, 1'b1);
      check("spur_valid", instr_valid, 1'b1);
    end
    repeat (hold) begin
      jumpr = 1'b1; jr_target = $urandom; pcsrc = 1'b1;
      tick();
      check("hold_instr", instr, word);
      check("hold_pc", pc, m_pc);
      check("hold_req", imem_req, 1'b0);
      check("hold_valid", instr_valid, 1'b1);
    end
    pcsrc = br; jump = jmp; jumpr = jr; signimm = simm; jr_target = jrt; advance = 1'b1;
    tick();
    advance = 1'b0; pcsrc = 1'b0; jump = 1'b0; jumpr = 1'b0;
    check("adv_lat", imem_req, 1'b1);
    if (jr)       tgt = jrt;
    else if (jmp) tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
    else if (br)  tgt = m_pc + 32'd4 + simm * 4;
    else          tgt = m_pc + 32'd4;
`ifdef IFETCH_DELAY_SLOT_EN
    if (m_pend) begin
      m_pc = m_pend_pc; m_pend = 1'b0;
    end else if (br || jmp || jr) begin
      m_pend = 1'b1; m_pend_pc = tgt; m_pc = m_pc + 32'd4;
    end else begin
      m_pc = m_pc + 32'd4;
    end
`else
    m_pc = tgt;
`endif
  endtask

  task automatic plain(input int lat, input int hold);
    step($urandom, lat, hold, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic goto(input logic [31:0] a);
    step($urandom, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, '0, a);
`ifdef IFETCH_DELAY_SLOT_EN
    plain(1, 0);
`endif
  endtask

  initial begin
    int n;
    do_reset();

    step(32'h2002_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("op_addi", op, 6'h08);
    wait_req();
    check("seq_addr", imem_addr, 32'h4);

    goto(32'h100);
    step($urandom, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, '0);
`ifdef IFETCH_DELAY_SLOT_EN
    wait_req();
    check("ds_slot_addr", imem_addr, 32'h104);
    step($urandom, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 32'hDEAD_BEE0);
`endif
    wait_req();
    check("branch_back", imem_addr, 32'hFC);

    goto(32'h0040_0010);
    step(32'h0810_0003, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5, '0);
`ifdef IFETCH_DELAY_SLOT_EN
    plain(1, 0);
`endif
    wait_req();
    check("jump_wins", imem_addr, 32'h0040_000C);

    step($urandom, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 32'h1234_5678);
`ifdef IFETCH_DELAY_SLOT_EN
    plain(1, 0);
`endif
    wait_req();
    check("jumpr_wins", imem_addr, 32'h1234_5678);

    goto(32'hFFFF_FFFC);
    plain(1, 0);
    wait_req();
    check("pc_wrap", imem_addr, 32'h0);

    plain(1, 10);
    plain(16, 0);

    wait_req();
    n = 0;
    do begin tick(); n++; end while (!imem_req && n < 40);
    check("tmo_cycles", n, 17);
    check("tmo_err", fetch_err, 1'b1);
    check("tmo_addr", imem_addr, m_pc);
    m_err = 1'b1;
    plain(2, 0);
    step($urandom, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

    do_reset();
    goto(32'h0000_0400);
    wait_req();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    imem_rvalid = 1'b1; imem_rdata = $urandom;
    tick();
    imem_rvalid = 1'b0;
    check("late_rv_req", imem_req, 1'b1);
    check("late_rv_addr", imem_addr, RPC);
    check("late_rv_err", fetch_err, 1'b0);

    for (int i = 0; i < 150; i++) begin
      step($urandom, $urandom_range(1, 6), $urandom_range(0, 3), 1'b0,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0),
           $urandom, $urandom);
    end
    wait_req();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
    $fatal(1, "bench did not finish");
  end

endmodule
